dcache_wb_direct: RTL

//  Direct-mapped, write-back, write-allocate data cache. It is the responder on the

---
 rtl/dcache_wb_direct_if.sv | 26 ++
 rtl/dcache_wb_direct.sv | 124 ++++++++++++
 2 files changed

// File: rtl/dcache_wb_direct_if.sv
// Core-side and memory-side signals of the direct-mapped write-back D-cache.
// The slave modport is the cache's view; the master modport is the core/memory environment.
interface dcache_wb_direct_if;
  logic         proc_read;
  logic         proc_write;
  logic [29:0]  proc_addr;
  logic [31:0]  proc_wdata;
  logic         proc_stall;
  logic [31:0]  proc_rdata;
  logic         mem_read;
  logic         mem_write;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic [127:0] mem_rdata;
  logic         mem_ready;

  modport slave (
    input  proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    output proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );

  modport master (
    output proc_read, proc_write, proc_addr, proc_wdata, mem_rdata, mem_ready,
    input  proc_stall, proc_rdata, mem_read, mem_write, mem_addr, mem_wdata
  );
endinterface

// File: rtl/dcache_wb_direct.sv
// Direct-mapped write-back write-allocate D-cache: hits complete in the same cycle,
// misses stall the core while the line is written back (if dirty) and refilled.
module dcache_wb_direct #(
  parameter int NUM_BLOCKS = 8
) (
  input logic               clk,
  input logic               proc_reset,
  dcache_wb_direct_if.slave bus
);
  localparam int IDX_W = $clog2(NUM_BLOCKS);
  localparam int TAG_W = 28 - IDX_W;

  typedef enum logic [1:0] {IDLE, WRITEBACK, ALLOCATE} state_t;

  state_t state, state_nxt;

  logic [127:0]          data_arr [NUM_BLOCKS];
  logic [TAG_W-1:0]      tag_arr  [NUM_BLOCKS];
  logic [NUM_BLOCKS-1:0] valid;
  logic [NUM_BLOCKS-1:0] dirty;

  logic [1:0]       off;
  logic [IDX_W-1:0] idx;
  logic [TAG_W-1:0] tag;
  logic             req;
  logic             hit;

  assign off = bus.proc_addr[1:0];
  assign idx = bus.proc_addr[IDX_W+1:2];
  assign tag = bus.proc_addr[29:IDX_W+2];
  assign req = bus.proc_read | bus.proc_write;
  assign hit = valid[idx] && (tag_arr[idx] == tag);

  logic         stall;
  logic [31:0]  rdata;
  logic         mem_rd;
  logic         mem_wr;
  logic [27:0]  mem_addr;
  logic [127:0] mem_wdata;
  logic         wr_hit;
  logic         wb_done;
  logic         refill;

  always_comb begin
    state_nxt = state;
    stall     = 1'b0;
    rdata     = '0;
    mem_rd    = 1'b0;
    mem_wr    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    wr_hit    = 1'b0;
    wb_done   = 1'b0;
    refill    = 1'b0;
    case (state)
      IDLE: begin
        if (req) begin
          if (hit) begin
            // A simultaneous read and write is handled as a write.
            wr_hit = bus.proc_write;
            if (!bus.proc_write) rdata = data_arr[idx][{off, 5'd0} +: 32];
          end else begin
            stall     = 1'b1;
            state_nxt = dirty[idx] ? WRITEBACK : ALLOCATE;
          end
        end
      end
      WRITEBACK: begin
        stall     = 1'b1;
        mem_wr    = 1'b1;
        mem_addr  = {tag_arr[idx], idx};
        mem_wdata = data_arr[idx];
        if (bus.mem_ready) begin
          wb_done   = 1'b1;
          state_nxt = ALLOCATE;
        end
      end
      ALLOCATE: begin
        stall    = 1'b1;
        mem_rd   = 1'b1;
        mem_addr = bus.proc_addr[29:2];
        if (bus.mem_ready) begin
          refill    = 1'b1;
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign bus.proc_stall = stall;
  assign bus.proc_rdata = rdata;
  assign bus.mem_read   = mem_rd;
  assign bus.mem_write  = mem_wr;
  assign bus.mem_addr   = mem_addr;
  assign bus.mem_wdata  = mem_wdata;

  always_ff @(posedge clk) begin
    if (proc_reset) begin
      state <= IDLE;
      valid <= '0;
      dirty <= '0;
    end else begin
      state <= state_nxt;
      if (wr_hit)  dirty[idx] <= 1'b1;
      if (wb_done) dirty[idx] <= 1'b0;
      if (refill) begin
        valid[idx] <= 1'b1;
        dirty[idx] <= 1'b0;
      end
    end
  end

  // Data and tags carry no reset; valid bits qualify them.
  always_ff @(posedge clk) begin
    if (!proc_reset) begin
      if (wr_hit) data_arr[idx][{off, 5'd0} +: 32] <= bus.proc_wdata;
      if (refill) begin
        data_arr[idx] <= bus.mem_rdata;
        tag_arr[idx]  <= tag;
      end
    end
  end
endmodule
